// File: rtl/ind_ram_port_sched_pkg.sv
// rtl/ind_ram_port_sched_pkg.sv - shared match-stage constants and RAM op type for the indirection port scheduler
package ind_ram_port_sched_pkg;

    localparam int IND_ADDR_W     = 8;
    localparam int IND_DATA_W     = 8;
    localparam int IND_TAG_W      = 1;
    localparam int IND_RAM_DEPTH  = 1 << IND_ADDR_W;
    localparam int IND_WQ_DEPTH   = 4;
    localparam int IND_STARVE_MAX = 16;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } ram_op_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ind_ram_port_sched_if.sv
// rtl/ind_ram_port_sched_if.sv - lookup, result, write, RAM and status signals of the port scheduler
interface ind_ram_port_sched_if
    import ind_ram_port_sched_pkg::*;
#(
    parameter int ADDR_W   = IND_ADDR_W,
    parameter int DATA_W   = IND_DATA_W,
    parameter int TAG_W    = IND_TAG_W,
    parameter int WQ_DEPTH = IND_WQ_DEPTH
);
    logic                          lk_valid;
    logic [ADDR_W-1:0]             lk_addr;
    logic [TAG_W-1:0]              lk_tag;
    logic                          lk_ready;
    logic                          rs_valid;
    logic [DATA_W-1:0]             rs_data;
    logic [TAG_W-1:0]              rs_tag;
    logic                          wr_valid;
    logic [ADDR_W-1:0]             wr_addr;
    logic [DATA_W-1:0]             wr_data;
    logic                          wr_ready;
    logic                          ram_en;
    logic                          ram_we;
    logic [ADDR_W-1:0]             ram_addr;
    logic [DATA_W-1:0]             ram_din;
    logic [DATA_W-1:0]             ram_dout;
    logic [$clog2(WQ_DEPTH):0]     wq_level;
    logic [15:0]                   force_cnt;

    modport slave (
        input  lk_valid, lk_addr, lk_tag, wr_valid, wr_addr, wr_data, ram_dout,
        output lk_ready, rs_valid, rs_data, rs_tag, wr_ready,
               ram_en, ram_we, ram_addr, ram_din, wq_level, force_cnt
    );

    modport master (
        output lk_valid, lk_addr, lk_tag, wr_valid, wr_addr, wr_data, ram_dout,
        input  lk_ready, rs_valid, rs_data, rs_tag, wr_ready,
               ram_en, ram_we, ram_addr, ram_din, wq_level, force_cnt
    );

endinterface

// File: rtl/ind_wq_fifo.sv
// rtl/ind_wq_fifo.sv - synchronous {addr,data} write queue with occupancy level
module ind_wq_fifo #(
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [AW-1:0]              push_addr_i,
    input  logic [DW-1:0]              push_data_i,
    input  logic                       pop_i,
    output logic [AW-1:0]              head_addr_o,
    output logic [DW-1:0]              head_data_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [AW+DW-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;

    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_i  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({push_i, pop_i})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem[wr_ptr_q] <= {push_addr_i, push_data_i};
        end
    end

    assign {head_addr_o, head_data_o} = mem[rd_ptr_q];
    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign level_o = level_q;

endmodule

// File: rtl/ind_ram_port_sched.sv
// rtl/ind_ram_port_sched.sv - shares one single-port indirection RAM between lookups and queued control writes
module ind_ram_port_sched
    import ind_ram_port_sched_pkg::*;
#(
    parameter int ADDR_W     = IND_ADDR_W,
    parameter int DATA_W     = IND_DATA_W,
    parameter int TAG_W      = IND_TAG_W,
    parameter int WQ_DEPTH   = IND_WQ_DEPTH,
    parameter int STARVE_MAX = IND_STARVE_MAX
) (
    input  logic                  clk,
    input  logic                  rst,
    ind_ram_port_sched_if.slave   bus
);
    localparam int LVL_W = $clog2(WQ_DEPTH) + 1;
    localparam int SV_W  = $clog2(STARVE_MAX + 2);
    localparam logic [SV_W-1:0] STARVE_LIM = SV_W'(STARVE_MAX);

    logic              wq_empty, wq_full, wq_push, wq_pop;
    logic [ADDR_W-1:0] wq_head_addr;
    logic [DATA_W-1:0] wq_head_data;
    logic [LVL_W-1:0]  wq_level;

    logic [SV_W-1:0]   starve_q, starve_d;
    logic [15:0]       force_cnt_q, force_cnt_d;
    logic              rs_valid_q, rs_valid_d;
    logic [TAG_W-1:0]  rs_tag_q, rs_tag_d;

    ram_op_e           op;
    logic              force_slot;

    ind_wq_fifo #(
        .AW    (ADDR_W),
        .DW    (DATA_W),
        .DEPTH (WQ_DEPTH)
    ) u_wq (
        .clk         (clk),
        .rst         (rst),
        .push_i      (wq_push),
        .push_addr_i (bus.wr_addr),
        .push_data_i (bus.wr_data),
        .pop_i       (wq_pop),
        .head_addr_o (wq_head_addr),
        .head_data_o (wq_head_data),
        .empty_o     (wq_empty),
        .full_o      (wq_full),
        .level_o     (wq_level)
    );

    // Lookups win unless a queued write has waited STARVE_MAX lookup cycles.
    always_comb begin
        force_slot = !wq_empty && (starve_q == STARVE_LIM);
        op         = OP_IDLE;
        if (rst)                op = OP_IDLE;
        else if (force_slot)    op = OP_WRITE;
        else if (bus.lk_valid)  op = OP_READ;
        else if (!wq_empty)     op = OP_WRITE;
    end

    assign wq_pop       = (op == OP_WRITE);
    assign wq_push      = bus.wr_valid && bus.wr_ready;
    assign bus.lk_ready = !rst && !force_slot;
    assign bus.wr_ready = !rst && !wq_full;
    assign bus.ram_en   = (op != OP_IDLE);
    assign bus.ram_we   = (op == OP_WRITE);
    assign bus.ram_addr = (op == OP_READ) ? bus.lk_addr : wq_head_addr;
    assign bus.ram_din  = wq_head_data;

    always_comb begin
        starve_d = starve_q;
        if (op == OP_WRITE || wq_empty)
            starve_d = '0;
        else if (op == OP_READ && starve_q != STARVE_LIM)
            starve_d = starve_q + SV_W'(1);

        force_cnt_d = (op == OP_WRITE && force_slot) ? sat_inc16(force_cnt_q) : force_cnt_q;
        rs_valid_d  = (op == OP_READ);
        rs_tag_d    = (op == OP_READ) ? bus.lk_tag : rs_tag_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q    <= '0;
            force_cnt_q <= '0;
            rs_valid_q  <= 1'b0;
            rs_tag_q    <= '0;
        end else begin
            starve_q    <= starve_d;
            force_cnt_q <= force_cnt_d;
            rs_valid_q  <= rs_valid_d;
            rs_tag_q    <= rs_tag_d;
        end
    end

    // A result already in flight when reset arrives is suppressed, not delivered.
    assign bus.rs_valid  = rs_valid_q && !rst;
    assign bus.rs_data   = bus.ram_dout;
    assign bus.rs_tag    = rs_tag_q;
    assign bus.wq_level  = wq_level;
    assign bus.force_cnt = force_cnt_q;

endmodule
